// File: rtl/link_word_source_pkg.sv
// Shared definitions for the device-side word link transmitter.
// Holds the link word width, synchronizer depth and the per-cycle link event encoding.
package link_word_source_pkg;

  localparam int LINK_WORD_W      = 16;
  localparam int LINK_SYNC_STAGES = 2;

  // Toggle detection stays masked until the synchronizer and history flop hold real strobe samples.
  localparam int LINK_ARM_CYCLES  = LINK_SYNC_STAGES + 1;

  typedef enum logic [1:0] {
    EV_IDLE     = 2'd0,
    EV_SEND     = 2'd1,
    EV_UNDERRUN = 2'd2
  } link_ev_e;

endpackage

// File: rtl/link_word_source_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and no write-to-read bypass.
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = '0;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;
  logic [DEPTH_LOG2:0]   level_next;

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    level_next = level;
    if (push_ok && !pop_ok) begin
      level_next = level + LVL_ONE;
    end else if (pop_ok && !push_ok) begin
      level_next = level - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_next;
      full  <= (level_next == LVL_FULL);
      empty <= (level_next == LVL_ZERO);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/link_word_source.sv
// Device-side link transmitter: queues words and presents one per receiver strobe toggle.
// Holds the strobe synchronizer, toggle detect, link output registers and statistics counters.
module link_word_source
  import link_word_source_pkg::*;
#(
  parameter int WORD_W     = LINK_WORD_W,
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                wr_en,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  input  logic                link_strobe,
  output logic [WORD_W-1:0]   link_data,
  output logic                link_valid,
  output logic [CNT_W-1:0]    sent_cnt,
  output logic [CNT_W-1:0]    underrun_cnt
);

  localparam logic [2:0]       ARM_DONE = 3'(LINK_ARM_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [LINK_SYNC_STAGES-1:0] sync_q;
  logic                        strobe_hist;
  logic [2:0]                  arm;
  logic                        arm_done;
  logic                        tog;
  link_ev_e                    ev;
  logic                        pop;
  logic [WORD_W-1:0]           head_data;

  sync_fifo #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      strobe_hist <= 1'b0;
      arm         <= '0;
    end else begin
      sync_q      <= {sync_q[LINK_SYNC_STAGES-2:0], link_strobe};
      strobe_hist <= sync_q[LINK_SYNC_STAGES-1];
      if (!arm_done) arm <= arm + 3'd1;
    end
  end

  // A strobe already high at reset release would look like an edge; ignore it until history is valid.
  assign arm_done = (arm == ARM_DONE);
  assign tog      = (sync_q[LINK_SYNC_STAGES-1] ^ strobe_hist) & arm_done;

  always_comb begin
    ev = EV_IDLE;
    if (tog) begin
      ev = empty ? EV_UNDERRUN : EV_SEND;
    end
  end

  assign pop = (ev == EV_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      link_data    <= '0;
      link_valid   <= 1'b0;
      sent_cnt     <= '0;
      underrun_cnt <= '0;
    end else begin
      case (ev)
        EV_SEND: begin
          link_data  <= head_data;
          link_valid <= 1'b1;
          sent_cnt   <= sent_cnt + CNT_ONE;
        end
        EV_UNDERRUN: begin
          link_valid <= 1'b0;
          if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
